// File: rtl/alu_result_collector_if.sv
// Return-path bundle between the four execution units, the result collector
// and the writeback consumer.
interface alu_result_collector_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              add_valid, sub_valid, mul_valid, div_valid;
  logic [DATA_W-1:0] add_res, sub_res, mul_res, div_res;
  logic [REG_W-1:0]  add_rd, sub_rd, mul_rd, div_rd;
  logic              add_flag, sub_flag, mul_flag, div_flag;
  logic              add_ready, sub_ready, mul_ready, div_ready;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rd;
  logic [1:0]        wb_op;
  logic              wb_flag;
  logic              busy;

  modport slave (
    input  add_valid, sub_valid, mul_valid, div_valid,
    input  add_res, sub_res, mul_res, div_res,
    input  add_rd, sub_rd, mul_rd, div_rd,
    input  add_flag, sub_flag, mul_flag, div_flag,
    output add_ready, sub_ready, mul_ready, div_ready,
    output wb_valid, wb_data, wb_rd, wb_op, wb_flag, busy,
    input  wb_ready
  );

  modport master (
    output add_valid, sub_valid, mul_valid, div_valid,
    output add_res, sub_res, mul_res, div_res,
    output add_rd, sub_rd, mul_rd, div_rd,
    output add_flag, sub_flag, mul_flag, div_flag,
    input  add_ready, sub_ready, mul_ready, div_ready,
    input  wb_valid, wb_data, wb_rd, wb_op, wb_flag, busy,
    output wb_ready
  );
endinterface

// File: rtl/alu_result_collector.sv
// Merges add/sub/mul/div results into one registered writeback stream using
// one holding slot per unit and a round-robin drain arbiter.
module alu_result_collector #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_result_collector_if.slave bus
);
  logic [3:0]        u_vld;
  logic [DATA_W-1:0] u_res  [4];
  logic [REG_W-1:0]  u_rd   [4];
  logic [3:0]        u_flag;
  logic [3:0]        u_rdy;
  logic [3:0]        u_acc;

  logic [3:0]        slot_vld_p0;
  logic [DATA_W-1:0] slot_res_p0  [4];
  logic [REG_W-1:0]  slot_rd_p0   [4];
  logic [3:0]        slot_flag_p0;
  logic [1:0]        rr_ptr;

  logic              wb_vld_p1;
  logic [DATA_W-1:0] wb_data_p1;
  logic [REG_W-1:0]  wb_rd_p1;
  logic [1:0]        wb_op_p1;
  logic              wb_flag_p1;

  logic              drain_en;
  logic              grant_en;
  logic [1:0]        grant_idx;

  always_comb begin
    u_vld     = {bus.div_valid, bus.mul_valid, bus.sub_valid, bus.add_valid};
    u_flag    = {bus.div_flag, bus.mul_flag, bus.sub_flag, bus.add_flag};
    u_res[0]  = bus.add_res;
    u_res[1]  = bus.sub_res;
    u_res[2]  = bus.mul_res;
    u_res[3]  = bus.div_res;
    u_rd[0]   = bus.add_rd;
    u_rd[1]   = bus.sub_rd;
    u_rd[2]   = bus.mul_rd;
    u_rd[3]   = bus.div_rd;
  end

  // Ready comes from registered slot state only, never from valid or wb_ready.
  assign u_rdy = {4{~rst}} & ~slot_vld_p0;
  assign u_acc = u_vld & u_rdy;

  assign bus.add_ready = u_rdy[0];
  assign bus.sub_ready = u_rdy[1];
  assign bus.mul_ready = u_rdy[2];
  assign bus.div_ready = u_rdy[3];

  assign drain_en = (~wb_vld_p1 | bus.wb_ready) & (|slot_vld_p0);

  // Walk downward so the slot closest to rr_ptr is the one left standing.
  always_comb begin
    grant_en  = 1'b0;
    grant_idx = '0;
    if (drain_en) begin
      for (int k = 3; k >= 0; k--) begin
        if (slot_vld_p0[rr_ptr + 2'(k)]) begin
          grant_en  = 1'b1;
          grant_idx = rr_ptr + 2'(k);
        end
      end
    end
  end

  // ---- stage p0: per-unit holding slots ----
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p0 <= '0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (grant_en && grant_idx == 2'(u))
          slot_vld_p0[u] <= 1'b0;
        else if (u_acc[u])
          slot_vld_p0[u] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (u_acc[u]) begin
        slot_res_p0[u]  <= u_res[u];
        slot_rd_p0[u]   <= u_rd[u];
        slot_flag_p0[u] <= u_flag[u];
      end
    end
  end

  // ---- stage p1: writeback register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_p1  <= 1'b0;
      wb_data_p1 <= '0;
      wb_rd_p1   <= '0;
      wb_op_p1   <= '0;
      wb_flag_p1 <= 1'b0;
      rr_ptr     <= '0;
    end else if (grant_en) begin
      wb_vld_p1  <= 1'b1;
      wb_data_p1 <= slot_res_p0[grant_idx];
      wb_rd_p1   <= slot_rd_p0[grant_idx];
      wb_op_p1   <= grant_idx;
      wb_flag_p1 <= slot_flag_p0[grant_idx];
      rr_ptr     <= grant_idx + 2'd1;
    end else if (wb_vld_p1 && bus.wb_ready) begin
      wb_vld_p1  <= 1'b0;
    end
  end

  assign bus.wb_valid = wb_vld_p1;
  assign bus.wb_data  = wb_data_p1;
  assign bus.wb_rd    = wb_rd_p1;
  assign bus.wb_op    = wb_op_p1;
  assign bus.wb_flag  = wb_flag_p1;
  assign bus.busy     = (|slot_vld_p0) | wb_vld_p1;
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed and randomized bench for alu_result_collector against a
// transaction-level model of slots, round-robin drain and writeback register.
module tb_alu_result_collector;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_collector_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();
  alu_result_collector #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic              u_valid [4];
  logic [DATA_W-1:0] u_res   [4];
  logic [REG_W-1:0]  u_rd    [4];
  logic              u_flag  [4];
  logic              wb_ready;
  logic              dut_ready [4];

  assign bus.add_valid = u_valid[0];
  assign bus.sub_valid = u_valid[1];
  assign bus.mul_valid = u_valid[2];
  assign bus.div_valid = u_valid[3];
  assign bus.add_res = u_res[0];
  assign bus.sub_res = u_res[1];
  assign bus.mul_res = u_res[2];
  assign bus.div_res = u_res[3];
  assign bus.add_rd = u_rd[0];
  assign bus.sub_rd = u_rd[1];
  assign bus.mul_rd = u_rd[2];
  assign bus.div_rd = u_rd[3];
  assign bus.add_flag = u_flag[0];
  assign bus.sub_flag = u_flag[1];
  assign bus.mul_flag = u_flag[2];
  assign bus.div_flag = u_flag[3];
  assign bus.wb_ready = wb_ready;
  assign dut_ready[0] = bus.add_ready;
  assign dut_ready[1] = bus.sub_ready;
  assign dut_ready[2] = bus.mul_ready;
  assign dut_ready[3] = bus.div_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: what each slot holds and what the writeback register shows.
  bit                m_full [4];
  logic [DATA_W-1:0] m_res  [4];
  logic [REG_W-1:0]  m_rd   [4];
  bit                m_flag [4];
  int                m_rr;
  bit                m_wbv;
  logic [DATA_W-1:0] m_wbd;
  logic [REG_W-1:0]  m_wbrd;
  int                m_wbop;
  bit                m_wbf;
  bit                acc [4];
  int                last_grant;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 4; u++) m_full[u] = 0;
    m_rr = 0; m_wbv = 0; m_wbd = '0; m_wbrd = '0; m_wbop = 0; m_wbf = 0;
  endtask

  task automatic tick();
    int g;
    for (int u = 0; u < 4; u++) acc[u] = !rst && !m_full[u] && u_valid[u];
    last_grant = -1;
    if (rst) begin
      model_reset();
    end else begin
      g = -1;
      if (!m_wbv || wb_ready)
        for (int k = 0; k < 4; k++)
          if (g < 0 && m_full[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      if (g >= 0) begin
        m_wbv = 1; m_wbd = m_res[g]; m_wbrd = m_rd[g]; m_wbop = g; m_wbf = m_flag[g];
        m_full[g] = 0; m_rr = (g + 1) % 4; last_grant = g;
      end else if (m_wbv && wb_ready) begin
        m_wbv = 0;
      end
      for (int u = 0; u < 4; u++)
        if (acc[u]) begin
          m_full[u] = 1; m_res[u] = u_res[u]; m_rd[u] = u_rd[u]; m_flag[u] = u_flag[u];
        end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
    chk("wb_data", 32'(bus.wb_data), 32'(m_wbd));
    chk("wb_rd", 32'(bus.wb_rd), 32'(m_wbrd));
    chk("wb_op", 32'(bus.wb_op), 32'(m_wbop));
    chk("wb_flag", 32'(bus.wb_flag), 32'(m_wbf));
    chk("busy", 32'(bus.busy), 32'(m_wbv || m_full[0] || m_full[1] || m_full[2] || m_full[3]));
    for (int u = 0; u < 4; u++)
      chk($sformatf("ready%0d", u), 32'(dut_ready[u]), 32'(!rst && !m_full[u]));
    for (int u = 0; u < 4; u++)
      if (acc[u]) u_valid[u] = 0;
  endtask

  task automatic offer(input int u, input logic [DATA_W-1:0] res, input logic [REG_W-1:0] rd,
                       input logic flag);
    u_valid[u] = 1; u_res[u] = res; u_rd[u] = rd; u_flag[u] = flag;
  endtask

  initial begin
    int n;
    bit found;
    logic [DATA_W-1:0] held;
    rst = 1; wb_ready = 1;
    for (int u = 0; u < 4; u++) offer(u, 16'(u + 1), 3'(u), 1'b0);
    model_reset();

    // Reset held two cycles with every unit offering
    tick(); tick();
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_add_ready", 32'(bus.add_ready), 0);
    for (int u = 0; u < 4; u++) u_valid[u] = 0;
    rst = 0;
    #1;
    for (int u = 0; u < 4; u++) chk($sformatf("rel_ready%0d", u), 32'(dut_ready[u]), 1);

    // Single add result
    offer(0, 16'h1234, 3'd5, 1'b0);
    tick();
    tick();
    chk("single_valid", 32'(bus.wb_valid), 1);
    chk("single_data", 32'(bus.wb_data), 32'h1234);
    chk("single_rd", 32'(bus.wb_rd), 5);
    chk("single_op", 32'(bus.wb_op), 0);
    tick();
    chk("single_done", 32'(bus.wb_valid), 0);
    chk("single_busy", 32'(bus.busy), 0);

    // Four-way collision from a fresh pointer
    rst = 1; tick(); rst = 0;
    for (int u = 0; u < 4; u++) offer(u, 16'h000A + 16'(u), 3'(u + 2), 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_op%0d", k), 32'(bus.wb_op), 32'(k));
      chk($sformatf("rr_data%0d", k), 32'(bus.wb_data), 32'h000A + 32'(k));
    end
    tick();

    // Backpressure: writeback stalls while mul and div deliver
    wb_ready = 0;
    offer(0, 16'h5555, 3'd1, 1'b1);
    tick(); tick();
    held = bus.wb_data;
    chk("bp_loaded", 32'(held), 32'h5555);
    offer(2, 16'h2222, 3'd2, 1'b0);
    offer(3, 16'h3333, 3'd3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_data", 32'(bus.wb_data), 32'h5555);
      chk("bp_hold_valid", 32'(bus.wb_valid), 1);
    end
    chk("bp_mul_ready", 32'(bus.mul_ready), 0);
    chk("bp_div_ready", 32'(bus.div_ready), 0);
    wb_ready = 1;
    tick();
    chk("bp_drain_mul", 32'(bus.wb_op), 2);
    tick();
    chk("bp_drain_div", 32'(bus.wb_data), 32'h3333);
    tick();
    chk("bp_empty", 32'(bus.busy), 0);

    // Fairness: add keeps streaming, one div result must get through within 4 writebacks
    offer(0, 16'h0100, 3'd4, 1'b0);
    offer(3, 16'hBEEF, 3'd7, 1'b1);
    n = 0; found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (last_grant >= 0) n++;
      if (bus.wb_valid && bus.wb_op == 2'd3) begin
        found = 1;
        chk("fair_data", 32'(bus.wb_data), 32'hBEEF);
        chk("fair_flag", 32'(bus.wb_flag), 1);
      end
      if (!u_valid[0]) offer(0, 16'h0100 + 16'(c), 3'd4, 1'b0);
    end
    chk("fair_seen", 32'(found), 1);
    chk("fair_within4", 32'(n <= 4), 1);
    u_valid[0] = 0;
    for (int k = 0; k < 4; k++) tick();

    // Reset mid-operation with sub/mul/div slots full and writeback pending
    wb_ready = 0;
    offer(1, 16'h0111, 3'd1, 1'b0);
    offer(2, 16'h0222, 3'd2, 1'b0);
    offer(3, 16'h0333, 3'd3, 1'b0);
    tick(); tick();
    offer(1, 16'h0444, 3'd4, 1'b0);
    tick();
    chk("mid_busy_before", 32'(bus.busy), 1);
    rst = 1;
    tick();
    rst = 0; wb_ready = 1;
    chk("mid_wb_valid", 32'(bus.wb_valid), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_stale", 32'(bus.wb_valid), 0);
    end

    // Randomized traffic with random backpressure and rare resets
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < 4; u++)
        if (!u_valid[u] && $urandom_range(0, 2) == 0)
          offer(u, 16'($urandom), 3'($urandom), 1'($urandom));
      wb_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; wb_ready = 1;
    for (int u = 0; u < 4; u++) u_valid[u] = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("final_idle", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Gathers results from the four execution units (add, sub, mul, div) and merges them into one registered writeback stream toward the register file.
- It is the return-path counterpart of the operand demux that fans rs1 out to the same four units by op_opcode.
- Each unit gets a one-entry holding slot with a valid/ready handshake, so multi-cycle units (mul, div) never lose results.
- A round-robin arbiter selects which slot drains into the writeback register.
- The writeback register supports backpressure from the consumer.

Parameters:
- DATA_W, 16, result data width (matches rs1_reg_val width).
- REG_W, 3, destination register index width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- add_valid, sub_valid, mul_valid, div_valid  in  1 each  unit result valid.
- add_res, sub_res, mul_res, div_res  in  DATA_W each  unit result data.
- add_rd, sub_rd, mul_rd, div_rd  in  REG_W each  destination register tag.
- add_flag, sub_flag, mul_flag, div_flag  in  1 each  unit status (overflow / divide-by-zero).
- add_ready, sub_ready, mul_ready, div_ready  out  1 each  collector can accept from that unit.
- wb_valid  out  1  writeback entry present.
- wb_ready  in  1  consumer accepts the writeback entry this cycle.
- wb_data  out  DATA_W  writeback result.
- wb_rd  out  REG_W  writeback destination tag.
- wb_op  out  2  source unit: 0 add, 1 sub, 2 mul, 3 div (same encoding as op_opcode).
- wb_flag  out  1  forwarded unit status.
- busy  out  1  any slot full or wb_valid high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it takes effect only on a rising clk edge.
- Reset values: all four slots empty; wb_valid=0, wb_data=0, wb_rd=0, wb_op=0, wb_flag=0; round-robin pointer rr_ptr=0; busy=0.
  - While rst is high, all *_ready outputs are 0.
  - Reset mid-operation discards every slot and the writeback entry. No stale entry appears after release.
- Ready: u_ready = !rst & !slot_full[u]. It depends only on registered state, so there is no combinational path from wb_ready or u_valid.
- Accept: on an edge where u_valid & u_ready, slot u captures res, rd and flag, and slot_full[u] becomes 1.
  - When u_ready is 0, the unit must hold its valid and data; the collector ignores them.
- Drain condition: when (!wb_valid | wb_ready) and any slot is full, the arbiter grants one slot. Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... mod 4.
- On a grant edge:
  - wb_* load from the granted slot, and wb_op = slot index.
  - wb_valid becomes 1.
  - The granted slot is cleared.
  - rr_ptr = (grant+1) mod 4.
- Consumer handshake: if wb_valid & wb_ready and no slot is full, wb_valid becomes 0. wb_data, wb_rd, wb_op and wb_flag hold their last values.
- Stall: while wb_valid & !wb_ready, all wb_* outputs stay stable and no grant occurs. Slots may still fill.
- Latency: a result accepted at edge N appears on wb_* after edge N+1 when the output path is free. Minimum latency is 2 cycles.
- Throughput:
  - Aggregate: 1 writeback per cycle.
  - Per unit: 1 result per 2 cycles, because a slot freed at the grant edge raises ready in the following cycle.
- Simultaneous events: a unit may be accepted into a slot on the same edge another slot is granted. A slot cannot be both accepted and granted on the same edge.
- Fairness: a full slot is granted within 4 consecutive grants.
- busy = |slot_full | wb_valid (registered-state derived).

Test Plan:
- Reset: hold rst 2 cycles with all *_valid=1 → all *_ready=0, wb_valid=0, busy=0; cycle after release → all *_ready=1.
- Single result: add_valid=1, add_res=0x1234, add_rd=5 at edge 0, wb_ready=1 → after edge 1: wb_valid=1, wb_data=0x1234, wb_rd=5, wb_op=0; after edge 2: wb_valid=0, busy=0.
- Four-way collision: all four units valid on the same edge (results 0x0A, 0x0B, 0x0C, 0x0D), wb_ready=1 → wb_op sequence 0,1,2,3 with data 0x0A..0x0D on 4 consecutive cycles; rr_ptr returns to 0.
- Backpressure: wb_valid=1 with wb_ready=0 for 5 cycles while mul and div deliver → wb_* unchanged for all 5 cycles; mul_ready and div_ready go 0 after capture; both drain once wb_ready=1.
- Fairness: add_valid held high continuously with wb_ready=1, div_valid pulsed once with div_res=0xBEEF and div_flag=1 → wb_op=3, wb_data=0xBEEF, wb_flag=1 seen within 4 writebacks.
- Reset mid-operation: sub, mul and div slots full and wb_valid=1, assert rst 1 cycle → next cycle wb_valid=0, busy=0; no 0-valued or stale writeback appears afterwards.
